// File: rtl/four_bits_demux.sv
// four_bits_demux
//
// Routes 4-bit words from one upstream source into two buffered output
// channels (external / internal), chosen per word by toExternal. Each
// channel owns a small FIFO and a transfer counter, so a stalled consumer
// on one side never loses data and never blocks the other side once the
// stalled channel's own FIFO has room.
//
// Handshake rule (applies to the input and both outputs): a transfer
// happens on a rising clk edge exactly when valid & ready are both 1 in
// the cycle before that edge. Valid never depends on the partner's ready,
// and inReady depends only on toExternal and stored occupancy, so there is
// no combinational path from extReady/intReady to inReady.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   inData/inValid/inReady upstream word + handshake
//   toExternal            destination of inData (1 external, 0 internal)
//   extData/extValid/extReady  external channel head word + handshake
//   intData/intValid/intReady  internal channel head word + handshake
//   extCount/intCount     completed output transfers per channel (wrapping)

module four_bits_demux_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [3:0]       wdata,
  output logic             full,
  output logic [3:0]       rdata,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [OW-1:0] occ;
  logic          do_push;
  logic          do_pop;

  assign valid   = (occ != '0);
  assign full    = (occ == FULL_OCC);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = valid & ready;
  // While non-empty the write pointer never equals the read pointer unless
  // full (and then no write happens), so rdata is stable until a pop.
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      occ   <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        count <= count + 1'b1;
      end
      if (do_push && !do_pop) begin
        occ <= occ + 1'b1;
      end else if (do_pop && !do_push) begin
        occ <= occ - 1'b1;
      end
    end
  end

endmodule

module four_bits_demux #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       inData,
  input  logic             inValid,
  input  logic             toExternal,
  output logic             inReady,
  output logic [3:0]       extData,
  output logic             extValid,
  input  logic             extReady,
  output logic [3:0]       intData,
  output logic             intValid,
  input  logic             intReady,
  output logic [CNT_W-1:0] extCount,
  output logic [CNT_W-1:0] intCount
);

  logic ext_full;
  logic int_full;
  logic ext_push;
  logic int_push;

  assign inReady  = toExternal ? ~ext_full : ~int_full;
  assign ext_push = inValid &  toExternal;
  assign int_push = inValid & ~toExternal;

  four_bits_demux_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ext (
    .clk   (clk),
    .reset (reset),
    .push  (ext_push),
    .wdata (inData),
    .full  (ext_full),
    .rdata (extData),
    .valid (extValid),
    .ready (extReady),
    .count (extCount)
  );

  four_bits_demux_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_int (
    .clk   (clk),
    .reset (reset),
    .push  (int_push),
    .wdata (inData),
    .full  (int_full),
    .rdata (intData),
    .valid (intValid),
    .ready (intReady),
    .count (intCount)
  );

endmodule

// File: tb/tb_four_bits_demux.sv
// Testbench for four_bits_demux: directed scenarios, a queue-based model
// of the two channels, a per-cycle compare process and literal checks.

module tb_four_bits_demux;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       inData = '0;
  logic             inValid = 1'b0;
  logic             toExternal = 1'b0;
  logic             inReady;
  logic [3:0]       extData;
  logic             extValid;
  logic             extReady = 1'b0;
  logic [3:0]       intData;
  logic             intValid;
  logic             intReady = 1'b0;
  logic [CNT_W-1:0] extCount;
  logic [CNT_W-1:0] intCount;

  always #5 clk = ~clk;

  four_bits_demux #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .inData     (inData),
    .inValid    (inValid),
    .toExternal (toExternal),
    .inReady    (inReady),
    .extData    (extData),
    .extValid   (extValid),
    .extReady   (extReady),
    .intData    (intData),
    .intValid   (intValid),
    .intReady   (intReady),
    .extCount   (extCount),
    .intCount   (intCount)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: channels are plain queues ----------------
  logic [3:0]       exp_ext_q[$];
  logic [3:0]       exp_int_q[$];
  logic [CNT_W-1:0] exp_ext_cnt;
  logic [CNT_W-1:0] exp_int_cnt;

  // Words the DUT actually delivered, for literal ordering checks.
  logic [3:0] ext_log[$];
  logic [3:0] int_log[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_ext_q.delete();
      exp_int_q.delete();
      exp_ext_cnt = '0;
      exp_int_cnt = '0;
    end else begin
      bit room, acc, pe, pi;
      room = toExternal ? (exp_ext_q.size() < DEPTH) : (exp_int_q.size() < DEPTH);
      acc  = inValid && room;
      pe   = extReady && (exp_ext_q.size() != 0);
      pi   = intReady && (exp_int_q.size() != 0);
      if (pe) begin void'(exp_ext_q.pop_front()); exp_ext_cnt = exp_ext_cnt + 1'b1; end
      if (pi) begin void'(exp_int_q.pop_front()); exp_int_cnt = exp_int_cnt + 1'b1; end
      if (acc) begin
        if (toExternal) exp_ext_q.push_back(inData);
        else            exp_int_q.push_back(inData);
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = toExternal ? (exp_ext_q.size() < DEPTH) : (exp_int_q.size() < DEPTH);
    chk("ext_valid", extValid, exp_ext_q.size() != 0);
    chk("int_valid", intValid, exp_int_q.size() != 0);
    chk("in_ready", inReady, exp_rdy);
    chk("ext_count", extCount, exp_ext_cnt);
    chk("int_count", intCount, exp_int_cnt);
    if (exp_ext_q.size() != 0) chk("ext_data", extData, exp_ext_q[0]);
    if (exp_int_q.size() != 0) chk("int_data", intData, exp_int_q[0]);
    if (reset) begin
      chk("ext_data_rst", extData, 4'h0);
      chk("int_data_rst", intData, 4'h0);
    end
    // Inputs are stable from here to the next rising edge.
    if (!reset && extValid && extReady) ext_log.push_back(extData);
    if (!reset && intValid && intReady) int_log.push_back(intData);
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [3:0] d, input logic ext);
    inData     = d;
    toExternal = ext;
    inValid    = 1'b1;
    cycle();
    inValid    = 1'b0;
  endtask

  task automatic do_reset();
    inValid  = 1'b0;
    extReady = 1'b0;
    intReady = 1'b0;
    reset    = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    ext_log.delete();
    int_log.delete();
    cycle();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // Reset held with inValid high: nothing stored, everything zero.
    reset = 1'b1;
    inValid = 1'b1; toExternal = 1'b1; inData = 4'hF;
    extReady = 1'b1; intReady = 1'b1;
    cycle(); cycle(); cycle();
    chk("rst_ext_valid", extValid, 1'b0);
    chk("rst_int_valid", intValid, 1'b0);
    chk("rst_ext_data", extData, 4'h0);
    chk("rst_int_data", intData, 4'h0);
    chk("rst_ext_count", extCount, 8'd0);
    chk("rst_int_count", intCount, 8'd0);
    chk("rst_ready_ext", inReady, 1'b1);
    toExternal = 1'b0; #1;
    chk("rst_ready_int", inReady, 1'b1);
    inValid = 1'b0;
    reset = 1'b0;
    cycle(); cycle();
    chk("post_rst_empty", {extValid, intValid}, 2'b00);

    // Routing with both consumers ready.
    do_reset();
    extReady = 1'b1; intReady = 1'b1;
    send(4'hA, 1'b1);
    chk("lat_ext_valid", extValid, 1'b1);
    chk("lat_ext_data", extData, 4'hA);
    send(4'h5, 1'b0);
    chk("lat_int_data", intData, 4'h5);
    send(4'h3, 1'b1);
    idle(3);
    chk("route_ext_n", ext_log.size(), 2);
    if (ext_log.size() == 2) begin
      chk("route_ext0", ext_log[0], 4'hA);
      chk("route_ext1", ext_log[1], 4'h3);
    end
    chk("route_int_n", int_log.size(), 1);
    if (int_log.size() == 1) chk("route_int0", int_log[0], 4'h5);
    chk("route_ext_count", extCount, 8'd2);
    chk("route_int_count", intCount, 8'd1);

    // Backpressure: external fills, internal still flows.
    do_reset();
    send(4'h1, 1'b1);
    send(4'h2, 1'b1);
    inData = 4'h4; toExternal = 1'b1; inValid = 1'b1; #1;
    chk("bp_full_ready", inReady, 1'b0);
    cycle();
    inData = 4'h7; toExternal = 1'b0; #1;
    chk("bp_int_ready", inReady, 1'b1);
    cycle();
    inValid = 1'b0; toExternal = 1'b1;
    extReady = 1'b1; #1;
    chk("bp_no_rdy_path", inReady, 1'b0);
    cycle();
    chk("bp_ready_back", inReady, 1'b1);
    cycle();
    intReady = 1'b1;
    idle(3);
    chk("bp_ext_n", ext_log.size(), 2);
    if (ext_log.size() == 2) begin
      chk("bp_ext0", ext_log[0], 4'h1);
      chk("bp_ext1", ext_log[1], 4'h2);
    end
    chk("bp_int_n", int_log.size(), 1);
    if (int_log.size() == 1) chk("bp_int0", int_log[0], 4'h7);

    // Push offered while full and popping: refused, then accepted next cycle.
    do_reset();
    send(4'h8, 1'b1);
    send(4'h9, 1'b1);
    extReady = 1'b1;
    inData = 4'hC; toExternal = 1'b1; inValid = 1'b1; #1;
    chk("sim_refused", inReady, 1'b0);
    cycle();
    chk("sim_ready_next", inReady, 1'b1);
    cycle();
    idle(3);
    chk("sim_ext_n", ext_log.size(), 3);
    if (ext_log.size() == 3) begin
      chk("sim_ext0", ext_log[0], 4'h8);
      chk("sim_ext1", ext_log[1], 4'h9);
      chk("sim_ext2", ext_log[2], 4'hC);
    end
    chk("sim_ext_count", extCount, 8'd3);

    // Counter wrap after 256 external transfers.
    do_reset();
    extReady = 1'b1; intReady = 1'b1;
    send(4'h6, 1'b0);
    for (int i = 0; i < 256; i++) send(4'(i), 1'b1);
    idle(3);
    chk("wrap_ext_n", ext_log.size(), 256);
    chk("wrap_ext_count", extCount, 8'd0);
    chk("wrap_int_count", intCount, 8'd1);

    // Asynchronous reset between edges with both FIFOs holding words.
    do_reset();
    extReady = 1'b1;
    send(4'h5, 1'b1);
    cycle();
    extReady = 1'b0;
    send(4'h1, 1'b1);
    send(4'h2, 1'b1);
    send(4'h3, 1'b0);
    chk("ar_pre_count", extCount, 8'd1);
    chk("ar_pre_valid", {extValid, intValid}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ext_valid", extValid, 1'b0);
    chk("ar_int_valid", intValid, 1'b0);
    chk("ar_ext_data", extData, 4'h0);
    chk("ar_int_data", intData, 4'h0);
    chk("ar_ext_count", extCount, 8'd0);
    chk("ar_int_count", intCount, 8'd0);
    cycle();
    reset = 1'b0;
    ext_log.delete();
    int_log.delete();
    extReady = 1'b1; intReady = 1'b1;
    idle(4);
    chk("ar_no_stale", ext_log.size() + int_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
